memory_access_stage: RTL

- Memory (M) stage of the 5-stage pipelined RISC-V core. Sits directly downstream of the EX/MA pipeline register and consumes its outputs.
- Drives the data-memory bus with a req/ready handshake.
- Performs byte/halfword/word store lane steering and load extraction with sign or zero extension.
- Raises a stall while the memory is not ready. Contains the MA/WB pipeline register feeding writeback.

---
 rtl/memory_access_stage_pkg.sv | 37 +++
 rtl/memory_access_stage_if.sv | 15 +
 rtl/memory_access_stage_load_store_align.sv | 52 +++++
 rtl/memory_access_stage.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory stage: funct3 encodings, result-select codes,
// FSM states and the MA/WB pipeline record.
package riscv_pkg;

   localparam int XLEN_P = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } maState_e;

   typedef struct packed {
      logic                regWrite;
      logic [1:0]          resultSrc;
      logic [XLEN_P-1:0]   aluResult;
      logic [XLEN_P-1:0]   readData;
      logic [4:0]          rd;
      logic [XLEN_P-1:0]   pcPlus4;
   } maWb_t;

   // Stores only allow B/H/W; loads additionally allow the unsigned variants.
   function automatic logic funct3Legal(input logic isStore, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!isStore) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      return ok;
   endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface memory_access_stage_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [3:0]      be;
   logic [XLEN-1:0] wdata;
   logic            ready;
   logic [XLEN-1:0] rdata;

   modport master (output req, we, addr, be, wdata, input ready, rdata);
   modport slave  (input req, we, addr, be, wdata, output ready, rdata);
endinterface

// File: rtl/memory_access_stage_load_store_align.sv
// Combinational lane steering for stores and byte/halfword extraction with
// sign or zero extension for loads.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addrLow_i,
   input  logic [31:0] storeData_i,
   input  logic [31:0] readWord_i,
   output logic [3:0]  byteEn_o,
   output logic [31:0] writeData_o,
   output logic [31:0] loadData_o
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   always_comb begin
      byteEn_o    = 4'b0000;
      writeData_o = 32'h0;
      case (funct3_i[1:0])
         2'b00: begin
            byteEn_o    = 4'b0001 << addrLow_i;
            writeData_o = {4{storeData_i[7:0]}};
         end
         2'b01: begin
            byteEn_o    = addrLow_i[1] ? 4'b1100 : 4'b0011;
            writeData_o = {2{storeData_i[15:0]}};
         end
         2'b10: begin
            byteEn_o    = 4'b1111;
            writeData_o = storeData_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      loadByte   = readWord_i[8*addrLow_i +: 8];
      loadHalf   = addrLow_i[1] ? readWord_i[31:16] : readWord_i[15:0];
      loadData_o = 32'h0;
      case (funct3_i)
         F3_B:    loadData_o = {{24{loadByte[7]}}, loadByte};
         F3_H:    loadData_o = {{16{loadHalf[15]}}, loadHalf};
         F3_W:    loadData_o = readWord_i;
         F3_BU:   loadData_o = {24'h0, loadByte};
         F3_HU:   loadData_o = {16'h0, loadHalf};
         default: loadData_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: drives the data bus, stalls the front of the pipe while memory
// is busy, aborts stuck accesses and holds the MA/WB pipeline register.
module memory_access_stage
   import riscv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            RegWriteM,
   input  logic [1:0]      ResultSrcM,
   input  logic            MemWriteM,
   input  logic [2:0]      Funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [4:0]      RdM,
   input  logic [XLEN-1:0] PCPlus4M,
   memory_access_stage_if.master dmem,
   output logic            StallM,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [4:0]      RdW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic            mem_fault
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   maState_e        state_q;
   logic [CW-1:0]   cnt_q;
   logic            fault_q;
   maWb_t           wb_q, wb_d;

   logic            isLoad, memOp, misalign, illegal, bad;
   logic            reqRaw, stallRaw, done, abort;
   logic [XLEN-1:0] loadData;

   assign isLoad   = (ResultSrcM == RESULT_SRC_MEM);
   assign memOp    = MemWriteM | isLoad;
   assign illegal  = ~funct3Legal(MemWriteM, Funct3M);
   assign misalign = ((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                     ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
   assign bad      = memOp & (misalign | illegal);

   load_store_align u_align (
      .funct3_i    (Funct3M),
      .addrLow_i   (ALUResultM[1:0]),
      .storeData_i (WriteDataM),
      .readWord_i  (dmem.rdata),
      .byteEn_o    (dmem.be),
      .writeData_o (dmem.wdata),
      .loadData_o  (loadData)
   );

   always_comb begin
      reqRaw   = 1'b0;
      stallRaw = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE: begin
            reqRaw   = memOp & ~bad;
            stallRaw = reqRaw & ~dmem.ready;
         end
         WAIT: begin
            reqRaw = 1'b1;
            if (!dmem.ready) begin
               if ((TIMEOUT != 0) && (cnt_q == TMO)) abort = 1'b1;
               else stallRaw = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign done = reqRaw & dmem.ready;

   // Gating with rst_n lets request and stall fall immediately on reset, even mid-wait.
   assign dmem.req  = reqRaw & rst_n;
   assign StallM    = stallRaw & rst_n;
   assign dmem.we   = MemWriteM;
   assign dmem.addr = {ALUResultM[XLEN-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         fault_q <= ((state_q == IDLE) & bad) | abort;
         case (state_q)
            IDLE: begin
               if (stallRaw) begin
                  state_q <= WAIT;
                  cnt_q   <= CW'(1);
               end
            end
            WAIT: begin
               if (done || abort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A stalled cycle retires a bubble; aborted or faulting accesses retire without writeback.
   always_comb begin
      wb_d = '0;
      if (!stallRaw) begin
         wb_d.regWrite  = RegWriteM & ~bad & ~abort;
         wb_d.resultSrc = ResultSrcM;
         wb_d.aluResult = ALUResultM;
         wb_d.readData  = (isLoad & done) ? loadData : '0;
         wb_d.rd        = RdM;
         wb_d.pcPlus4   = PCPlus4M;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wb_q <= '0;
      else        wb_q <= wb_d;
   end

   assign RegWriteW  = wb_q.regWrite;
   assign ResultSrcW = wb_q.resultSrc;
   assign ALUResultW = wb_q.aluResult;
   assign ReadDataW  = wb_q.readData;
   assign RdW        = wb_q.rd;
   assign PCPlus4W   = wb_q.pcPlus4;
   assign mem_fault  = fault_q;

endmodule
